// File: rtl/hsv_core_regfile_ctrl_if.sv
// Writeback, read-request, operand-response and regfile-port signals of the
// register file controller; slave is the controller, master is everything around it.
interface hsv_core_regfile_ctrl_if #(
  parameter int NUM_WB = 3
);
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB-1:0]       wb_ready;
  logic [NUM_WB-1:0][4:0]  wb_addr;
  logic [NUM_WB-1:0][31:0] wb_data;

  logic        rd_valid;
  logic        rd_ready;
  logic [4:0]  rd_rs1_addr;
  logic [4:0]  rd_rs2_addr;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rs1_data;
  logic [31:0] rsp_rs2_data;

  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;

  logic        init_done;

  modport slave (
    input  wb_valid, wb_addr, wb_data, rd_valid, rd_rs1_addr, rd_rs2_addr,
           rsp_ready, rf_rs1_data, rf_rs2_data,
    output wb_ready, rd_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data,
           rf_rs1_addr, rf_rs2_addr, rf_wr_en, rf_wr_addr, rf_wr_data, init_done
  );

  modport master (
    output wb_valid, wb_addr, wb_data, rd_valid, rd_rs1_addr, rd_rs2_addr,
           rsp_ready, rf_rs1_data, rf_rs2_data,
    input  wb_ready, rd_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data,
           rf_rs1_addr, rf_rs2_addr, rf_wr_en, rf_wr_addr, rf_wr_data, init_done
  );
endinterface

// File: rtl/hsv_core_regfile_ctrl.sv
// Register file controller: zeroes the file after reset, round-robin arbitrates
// writeback units onto the write port and serves forwarded, stall-safe rs1/rs2 reads.
module hsv_core_regfile_ctrl #(
  parameter int NUM_WB    = 3,
  parameter bit INIT_ZERO = 1'b1
) (
  input logic                    clk_core,
  input logic                    rst_n,
  hsv_core_regfile_ctrl_if.slave bus
);
  localparam int PTR_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  localparam state_e RESET_STATE = INIT_ZERO ? ST_INIT : ST_RUN;

  state_e           state, state_next;
  logic [4:0]       init_cnt;
  logic [PTR_W-1:0] rr_ptr;
  logic             init_done_q;
  logic             grant_any;
  logic [PTR_W-1:0] grant_idx;

  logic        rsp_valid_q, rsp_fresh_q;
  logic [4:0]  rs1_q, rs2_q;
  logic        fwd1_q, fwd2_q;
  logic [31:0] fwd_data_q;
  logic [31:0] hold1_q, hold2_q;
  logic        rd_fire, rsp_stall;

  // Round-robin scan starting at rr_ptr, wrapping around the unit list.
  always_comb begin
    logic [PTR_W-1:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      idx = PTR_W'((int'(rr_ptr) + i) % NUM_WB);
      if (!grant_any && bus.wb_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_STATE;
      init_cnt    <= '0;
      rr_ptr      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state       <= state_next;
      init_done_q <= (state_next == ST_RUN);
      if (state == ST_INIT) init_cnt <= init_cnt + 5'd1;
      if (state == ST_RUN && grant_any)
        rr_ptr <= PTR_W'((int'(grant_idx) + 1) % NUM_WB);
    end
  end

  always_comb begin
    state_next = state;
    if (state == ST_INIT && init_cnt == 5'd31) state_next = ST_RUN;
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    bus.wb_ready   = '0;
    bus.rd_ready   = 1'b0;
    bus.rf_wr_en   = 1'b0;
    bus.rf_wr_addr = '0;
    bus.rf_wr_data = '0;
    unique case (state)
      ST_INIT: begin
        bus.rf_wr_en   = 1'b1;
        bus.rf_wr_addr = init_cnt;
      end
      ST_RUN: begin
        bus.rd_ready = !rsp_valid_q || bus.rsp_ready;
        if (grant_any) begin
          bus.wb_ready[grant_idx] = 1'b1;
          // x0 writes are acknowledged but never reach the array.
          bus.rf_wr_en   = (bus.wb_addr[grant_idx] != 5'd0);
          bus.rf_wr_addr = bus.wb_addr[grant_idx];
          bus.rf_wr_data = bus.wb_data[grant_idx];
        end
      end
      default: ;
    endcase
  end

  assign rd_fire         = bus.rd_valid && bus.rd_ready;
  assign rsp_stall       = rsp_valid_q && !bus.rsp_ready;
  assign bus.rf_rs1_addr = bus.rd_rs1_addr;
  assign bus.rf_rs2_addr = bus.rd_rs2_addr;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.init_done   = init_done_q;

  function automatic logic [31:0] operand(input logic [4:0]  addr,
                                          input logic        fresh,
                                          input logic        fwd,
                                          input logic [31:0] fwd_data,
                                          input logic [31:0] rf_data,
                                          input logic [31:0] hold);
    if (addr == 5'd0) return '0;
    if (!fresh) return hold;
    return fwd ? fwd_data : rf_data;
  endfunction

  assign bus.rsp_rs1_data = operand(rs1_q, rsp_fresh_q, fwd1_q, fwd_data_q, bus.rf_rs1_data, hold1_q);
  assign bus.rsp_rs2_data = operand(rs2_q, rsp_fresh_q, fwd2_q, fwd_data_q, bus.rf_rs2_data, hold2_q);

  // A same-edge write wins over the regfile's read-before-write value, both on
  // accept (forward flag) and while a stalled response is being held.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_fresh_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      fwd1_q      <= 1'b0;
      fwd2_q      <= 1'b0;
      fwd_data_q  <= '0;
      hold1_q     <= '0;
      hold2_q     <= '0;
    end else if (rd_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_fresh_q <= 1'b1;
      rs1_q       <= bus.rd_rs1_addr;
      rs2_q       <= bus.rd_rs2_addr;
      fwd1_q      <= bus.rf_wr_en && (bus.rf_wr_addr == bus.rd_rs1_addr);
      fwd2_q      <= bus.rf_wr_en && (bus.rf_wr_addr == bus.rd_rs2_addr);
      fwd_data_q  <= bus.rf_wr_data;
    end else if (rsp_stall) begin
      rsp_fresh_q <= 1'b0;
      hold1_q <= (bus.rf_wr_en && bus.rf_wr_addr == rs1_q) ? bus.rf_wr_data : bus.rsp_rs1_data;
      hold2_q <= (bus.rf_wr_en && bus.rf_wr_addr == rs2_q) ? bus.rf_wr_data : bus.rsp_rs2_data;
    end else if (rsp_valid_q) begin
      rsp_valid_q <= 1'b0;
      rsp_fresh_q <= 1'b0;
    end
  end
endmodule
